// File: rtl/timer_pkg.sv
// Shared types and default constants for the countdown timer.
package timer_pkg;

    // Top-level controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } timer_state_t;

    localparam int TIMER_DELAY_W         = 4;
    localparam int TIMER_CYCLES_PER_UNIT = 1000;

endpackage

// File: rtl/timer_prescale.sv
// Unit prescaler: counts 0..CYCLES_PER_UNIT-1 while run is high and pulses
// tick on the last count of each unit.
module timer_prescale #(
    parameter int CYCLES_PER_UNIT = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic tick
);

    localparam int CW = (CYCLES_PER_UNIT > 1) ? $clog2(CYCLES_PER_UNIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CYCLES_PER_UNIT - 1);

    logic [CW-1:0] cnt_reg;

    assign tick = run && (cnt_reg == LAST);

    // Free-running unit counter, wrapping on tick and held at zero by clear
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_reg <= '0;
        end else if (run) begin
            cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// Programmable countdown timer: shifts a delay in serially while shift_ena
// is high, counts (delay+1) units after shift_ena falls, then holds done
// until ack. Optional feature macro: TIMER_ABORT_EN adds an abort input.
module countdown_timer
    import timer_pkg::*;
#(
    parameter int DELAY_W         = TIMER_DELAY_W,
    parameter int CYCLES_PER_UNIT = TIMER_CYCLES_PER_UNIT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               shift_ena,
    input  logic               data,
    input  logic               ack,
`ifdef TIMER_ABORT_EN
    input  logic               abort,
`endif
    output logic               counting,
    output logic               done,
    output logic [DELAY_W-1:0] count
);

    timer_state_t       state_reg, state_next;
    logic [DELAY_W-1:0] delay_reg, delay_next;
    logic [DELAY_W-1:0] delay_shifted;
    logic               ena_q_reg;
    logic               presc_clear;
    logic               tick;

    // Delay register shifted left by one with the serial bit entering at the LSB
    assign delay_shifted[0] = data;
    generate
        for (genvar gi = 1; gi < DELAY_W; gi++) begin : g_shift
            assign delay_shifted[gi] = delay_reg[gi-1];
        end
    endgenerate

    // Prescaler sits at zero outside COUNT so each run starts on a fresh unit
    always_comb begin
        presc_clear = (state_reg != COUNT);
`ifdef TIMER_ABORT_EN
        if (abort) begin
            presc_clear = 1'b1;
        end
`endif
    end

    timer_prescale #(
        .CYCLES_PER_UNIT (CYCLES_PER_UNIT)
    ) u_prescale (
        .clk   (clk),
        .reset (reset),
        .clear (presc_clear),
        .run   (state_reg == COUNT),
        .tick  (tick)
    );

    // Next-state and delay-register update
    always_comb begin
        state_next = state_reg;
        delay_next = delay_reg;
        case (state_reg)
            IDLE: begin
                if (shift_ena) begin
                    delay_next = delay_shifted;
                end else if (ena_q_reg) begin
                    state_next = COUNT;
                end
            end
            COUNT: begin
                if (tick) begin
                    if (delay_reg != '0) begin
                        delay_next = delay_reg - 1'b1;
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                if (ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
`ifdef TIMER_ABORT_EN
        // Abort wins over the unit wrap and over ack
        if (abort && (state_reg != IDLE)) begin
            state_next = IDLE;
            delay_next = '0;
        end
`endif
    end

    // State, delay and shift_ena history; history only lives in IDLE so a
    // held-high strobe left over from COUNT/DONE cannot restart the timer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            delay_reg <= '0;
            ena_q_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            delay_reg <= delay_next;
            ena_q_reg <= (state_reg == IDLE) ? shift_ena : 1'b0;
        end
    end

    assign counting = (state_reg == COUNT);
    assign done     = (state_reg == DONE);
    assign count    = delay_reg;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer with CYCLES_PER_UNIT=4.
// Build with TIMER_ABORT_EN defined to also exercise the abort input.
module tb_countdown_timer;

    localparam int DW  = 4;
    localparam int CPU = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          shift_ena;
    logic          data;
    logic          ack;
    logic          abort;
    logic          counting;
    logic          done;
    logic [DW-1:0] count;

    int total = 0;
    int bad   = 0;
    int model = 0;   // reference delay value

    countdown_timer #(
        .DELAY_W         (DW),
        .CYCLES_PER_UNIT (CPU)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .shift_ena (shift_ena),
        .data      (data),
        .ack       (ack),
`ifdef TIMER_ABORT_EN
        .abort     (abort),
`endif
        .counting  (counting),
        .done      (done),
        .count     (count)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        total++;
        assert (obs === 32'(exp)) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Shift nbits bits in MSB first; leaves the bench just after the last shift edge
    task automatic shift_in(input int nbits, input logic [31:0] bits);
        for (int i = nbits - 1; i >= 0; i--) begin
            shift_ena = 1'b1;
            data      = bits[i];
            model     = ((model * 2) + int'(bits[i])) % (1 << DW);
            step();
        end
        shift_ena = 1'b0;
        data      = 1'b0;
        $display("shift %0d bits value=%0h -> delay %0d", nbits, bits, model);
    endtask

    // Follow one counting run; stop_at>=0 returns early while still counting,
    // inj_at injects a shift pulse, rand_ack drives random ack during COUNT
    task automatic run_count(input int stop_at, input int inj_at, input bit rand_ack);
        int n;
        int d;
        d = model;
        chk("pre_counting", counting, 0);
        step();
        n = 0;
        while (counting === 1'b1 && n < 300 && n != stop_at) begin
            chk("count_step", count, d - n / CPU);
            shift_ena = (n == inj_at);
            data      = (n == inj_at);
            ack       = rand_ack ? 1'($urandom_range(0, 1)) : 1'b0;
            n++;
            step();
        end
        shift_ena = 1'b0;
        data      = 1'b0;
        ack       = 1'b0;
        if (stop_at >= 0) begin
            chk("stop_reached", n, stop_at);
            $display("count run delay=%0d interrupted at cycle %0d", d, n);
            return;
        end
        chk("duration", n, (d + 1) * CPU);
        chk("done_rise", done, 1);
        chk("count_in_done", count, 0);
        model = 0;
        $display("count run delay=%0d cycles=%0d done=%0d", d, n, done);
    endtask

    // Hold in DONE for hold cycles, then acknowledge (optionally with a shift strobe)
    task automatic do_ack(input int hold, input bit with_shift);
        for (int i = 0; i < hold; i++) begin
            chk("done_hold", done, 1);
            step();
        end
        ack       = 1'b1;
        shift_ena = with_shift;
        data      = with_shift;
        step();
        ack       = 1'b0;
        shift_ena = 1'b0;
        data      = 1'b0;
        chk("done_fall", done, 0);
        chk("idle_counting", counting, 0);
        chk("idle_count", count, 0);
        repeat (6) step();
        chk("no_restart", counting, 0);
        chk("no_restart_count", count, 0);
        $display("ack after %0d cycles shift=%0d done=%0d", hold, with_shift, done);
    endtask

    initial begin
        reset     = 1'b1;
        shift_ena = 1'b0;
        data      = 1'b0;
        ack       = 1'b0;
        abort     = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        chk("rst_counting", counting, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        $display("reset released counting=%0d done=%0d count=%0d", counting, done, count);

        // 1101 -> 13, 56 cycles, then ack held off for 20 cycles
        shift_in(4, 32'b1101);
        chk("count_13", count, 13);
        run_count(-1, -1, 1'b0);
        do_ack(20, 1'b0);

        // Boundary delays
        shift_in(4, 32'b0000);
        run_count(-1, -1, 1'b0);
        do_ack(1, 1'b0);
        shift_in(4, 32'b1111);
        run_count(-1, -1, 1'b0);
        do_ack(0, 1'b0);

        // Shift strobe during COUNT and together with ack must be ignored
        shift_in(4, 32'b0101);
        run_count(-1, 9, 1'b0);
        do_ack(2, 1'b1);

        // Reset in the middle of COUNT
        shift_in(4, 32'b0111);
        run_count(2, -1, 1'b0);
        chk("pre_reset_count", count, 7);
        reset = 1'b1;
        step();
        reset = 1'b0;
        model = 0;
        chk("midrst_counting", counting, 0);
        chk("midrst_done", done, 0);
        chk("midrst_count", count, 0);
        $display("reset during count counting=%0d count=%0d", counting, count);
        shift_in(4, 32'b0010);
        run_count(-1, -1, 1'b0);
        do_ack(1, 1'b0);

`ifdef TIMER_ABORT_EN
        // Abort during COUNT at count 5
        shift_in(4, 32'b0111);
        run_count(9, -1, 1'b0);
        chk("pre_abort_count", count, 5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        model = 0;
        chk("abort_counting", counting, 0);
        chk("abort_done", done, 0);
        chk("abort_count", count, 0);
        $display("abort in count counting=%0d count=%0d", counting, count);
        // Abort together with ack in DONE
        shift_in(4, 32'b0001);
        run_count(-1, -1, 1'b0);
        abort = 1'b1;
        ack   = 1'b1;
        step();
        abort = 1'b0;
        ack   = 1'b0;
        chk("abort_ack_done", done, 0);
        chk("abort_ack_count", count, 0);
        chk("abort_ack_counting", counting, 0);
        $display("abort with ack in done done=%0d count=%0d", done, count);
`endif

        // Randomized bursts, random ack noise and random ack latency
        for (int it = 0; it < 6; it++) begin
            int          nb;
            logic [31:0] bits;
            if (it == 0) begin
                ack = 1'b1;   // ack while idle must not be remembered
                step();
                ack = 1'b0;
                step();
                chk("idle_ack_done", done, 0);
            end
            nb   = int'($urandom_range(1, 7));
            bits = $urandom;
            shift_in(nb, bits);
            run_count(-1, -1, 1'b1);
            do_ack(int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
